// File: rtl/bias_add_stream.sv
// -----------------------------------------------------------------------------
// bias_add_stream
//
// Consumer end of the bias coefficient stream. At the start of every frame it
// pops N_CH biases into a local bank. It then adds the per-channel bias to a
// channel-interleaved accumulator stream, arithmetic-shifts the sum right by
// SHIFT, saturates it to OUT_W bits and pushes the result downstream.
//
// Optional feature (compile-time macro):
//   BIAS_ADD_RELU_EN  - when defined, negative saturated results are clamped
//                       to zero (ReLU fused after the bias add).
//
// Ports:
//   ap_clk          in   clock, rising edge
//   ap_rst          in   synchronous reset, active-high
//   bias_V_dout     in   bias stream data (signed, COEFF_W)
//   bias_V_empty_n  in   bias stream non-empty
//   bias_V_read     out  bias pop
//   acc_V_dout      in   accumulator stream data (signed, ACC_W)
//   acc_V_empty_n   in   accumulator stream non-empty
//   acc_V_read      out  accumulator pop
//   output_V_din    out  result data (signed, OUT_W)
//   output_V_full_n in   output stream not full
//   output_V_write  out  output push
//   frame_done      out  pulses when the last sample of a frame is pushed
// -----------------------------------------------------------------------------
module bias_add_stream #(
  parameter int N_CH    = 16,
  parameter int N_PIX   = 64,
  parameter int COEFF_W = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 8
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic signed [COEFF_W-1:0] bias_V_dout,
  input  logic                      bias_V_empty_n,
  output logic                      bias_V_read,
  input  logic signed [ACC_W-1:0]   acc_V_dout,
  input  logic                      acc_V_empty_n,
  output logic                      acc_V_read,
  output logic signed [OUT_W-1:0]   output_V_din,
  input  logic                      output_V_full_n,
  output logic                      output_V_write,
  output logic                      frame_done
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

  // Saturation bounds expressed in the widened sum domain.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                    state;
  logic [CH_W-1:0]           ch_cnt;
  logic [PIX_W-1:0]          pix_cnt;
  logic signed [COEFF_W-1:0] bank [N_CH];

  logic                      bias_pop;
  logic                      acc_pop;
  logic                      push;
  logic                      last_sample;

  logic signed [ACC_W:0]     sum_p0;
  logic signed [ACC_W:0]     shifted_p0;
  logic signed [OUT_W-1:0]   result_p0;

  logic signed [OUT_W-1:0]   out_data_p1;
  logic                      vld_p1;
  logic                      last_p1;

  // Sign-extend both operands to ACC_W+1 bits so the add can never wrap.
  function automatic logic signed [ACC_W:0] bias_sum(
    input logic signed [ACC_W-1:0]   a,
    input logic signed [COEFF_W-1:0] b
  );
    logic signed [ACC_W:0] a_x;
    logic signed [ACC_W:0] b_x;
    a_x = {a[ACC_W-1], a};
    b_x = {{(ACC_W + 1 - COEFF_W){b[COEFF_W-1]}}, b};
    return a_x + b_x;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(
    input logic signed [ACC_W:0] v
  );
    logic signed [ACC_W:0] c;
    if (v > SAT_MAX)      c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else                  c = v;
    return c[OUT_W-1:0];
  endfunction

`ifdef BIAS_ADD_RELU_EN
  function automatic logic signed [OUT_W-1:0] relu(
    input logic signed [OUT_W-1:0] v
  );
    return v[OUT_W-1] ? '0 : v;
  endfunction
`endif

  // Handshakes are suppressed while reset is held so no FIFO entry is
  // consumed or produced by a cycle whose effect is being discarded.
  always_comb begin
    bias_pop    = !ap_rst && (state == LOAD) && bias_V_empty_n;
    push        = !ap_rst && vld_p1 && output_V_full_n;
    acc_pop     = !ap_rst && (state == RUN) && acc_V_empty_n &&
                  (!vld_p1 || output_V_full_n);
    last_sample = (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);
  end

  assign bias_V_read    = bias_pop;
  assign acc_V_read     = acc_pop;
  assign output_V_write = push;
  assign output_V_din   = vld_p1 ? out_data_p1 : '0;
  assign frame_done     = push && last_p1;

  // ---- stage p0: bias add, rescale, saturate (combinational on pop) ----
  always_comb begin
    sum_p0     = bias_sum(acc_V_dout, bank[ch_cnt]);
    shifted_p0 = sum_p0 >>> SHIFT;
`ifdef BIAS_ADD_RELU_EN
    result_p0  = relu(saturate(shifted_p0));
`else
    result_p0  = saturate(shifted_p0);
`endif
  end

  // Control: state, counters and output-valid tracking.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= LOAD;
      ch_cnt  <= '0;
      pix_cnt <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bias_pop) begin
            if (ch_cnt == CH_LAST) begin
              ch_cnt <= '0;
              state  <= RUN;
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (acc_pop) begin
            if (ch_cnt == CH_LAST) begin
              ch_cnt <= '0;
              if (pix_cnt == PIX_LAST) begin
                pix_cnt <= '0;
                state   <= LOAD;
              end else begin
                pix_cnt <= pix_cnt + 1'b1;
              end
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
        end
      endcase

      // A pop refills the output register even when it is being pushed in
      // the same cycle; a push alone drains it. The last sample of a frame
      // may still be held here while the next frame's biases are loading.
      if (acc_pop) begin
        vld_p1  <= 1'b1;
        last_p1 <= last_sample;
      end else if (push) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  // ---- stage p1: bias bank and output data register (no reset) ----
  always_ff @(posedge ap_clk) begin
    if (bias_pop) bank[ch_cnt] <= bias_V_dout;
    if (acc_pop)  out_data_p1  <= result_p0;
  end

endmodule
